// File: rtl/dmem_master.sv
//-----------------------------------------------------------------------------
// dmem_master
//
// Turns one 32-bit word load or store from a CPU into four byte-wide
// accesses on a byte-addressed data memory. Words are big-endian: the byte
// at the base address is the most significant one. Byte addresses wrap
// modulo 2^AW, and no alignment check is made.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   req        : CPU access request, sampled only while ready=1
//   we         : 1 = word store, 0 = word load (sampled with req)
//   addr       : byte address of the word's MSB (sampled with req)
//   wdata      : store data (sampled with req)
//   ready      : idle and able to accept a request
//   done       : one-cycle completion pulse
//   rdata      : last loaded word, held until the next load completes
//   daddr      : byte address presented to the memory (registered)
//   mem_wbyte  : store byte presented to the memory (registered)
//   mem_rbyte  : memory read byte, valid one cycle after MemRead
//   MemRead    : byte read strobe (registered)
//   MemWrite   : byte write strobe (registered)
//
// Timing from the accept edge:
//   store : MemWrite in cycles 1-4, done in cycle 5, ready in cycle 6
//   load  : MemRead in cycles 1-4, captures at the ends of cycles 2-5,
//           done in cycle 6, ready in cycle 7
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module dmem_master #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          done,
    output logic [31:0]   rdata,
    output logic [AW-1:0] daddr,
    output logic [7:0]    mem_wbyte,
    input  logic [7:0]    mem_rbyte,
    output logic          MemRead,
    output logic          MemWrite
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_base, w_base_next;
    logic [31:0]   r_wdata, w_wdata_next;
    logic [1:0]    r_cnt, w_cnt_next;       // byte being presented to memory
    logic [1:0]    r_ccnt, w_ccnt_next;     // byte being captured on a load
    logic          r_pend, w_pend_next;     // a read was presented last cycle
    logic [31:0]   r_shift, w_shift_next;
    logic [31:0]   r_rdata, w_rdata_next;
    logic [AW-1:0] r_daddr, w_daddr_next;
    logic [7:0]    r_wbyte, w_wbyte_next;
    logic          r_memread, w_memread_next;
    logic          r_memwrite, w_memwrite_next;

    logic [1:0]    w_cnt_inc;
    logic [AW-1:0] w_addr_inc;

    // Big-endian byte select: index 0 is the most significant byte.
    function automatic logic [7:0] sel_byte(input logic [31:0] word,
                                            input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    assign w_cnt_inc  = r_cnt + 2'd1;
    // Natural AW-bit addition gives the required modulo-2^AW wrap.
    assign w_addr_inc = r_base + {{(AW-2){1'b0}}, w_cnt_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_ccnt     <= '0;
            r_pend     <= 1'b0;
            r_shift    <= '0;
            r_rdata    <= '0;
            r_daddr    <= '0;
            r_wbyte    <= '0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_base     <= w_base_next;
            r_wdata    <= w_wdata_next;
            r_cnt      <= w_cnt_next;
            r_ccnt     <= w_ccnt_next;
            r_pend     <= w_pend_next;
            r_shift    <= w_shift_next;
            r_rdata    <= w_rdata_next;
            r_daddr    <= w_daddr_next;
            r_wbyte    <= w_wbyte_next;
            r_memread  <= w_memread_next;
            r_memwrite <= w_memwrite_next;
        end
    end

    // Next-state logic. The memory-side outputs are computed one cycle
    // ahead and registered, so the strobes and address are glitch-free.
    always_comb begin
        w_state_next    = r_state;
        w_base_next     = r_base;
        w_wdata_next    = r_wdata;
        w_cnt_next      = r_cnt;
        w_ccnt_next     = r_ccnt;
        w_pend_next     = r_memread;
        w_shift_next    = r_shift;
        w_rdata_next    = r_rdata;
        w_daddr_next    = r_daddr;
        w_wbyte_next    = r_wbyte;
        w_memread_next  = 1'b0;
        w_memwrite_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_base_next  = addr;
                    w_wdata_next = wdata;
                    w_cnt_next   = 2'd0;
                    w_ccnt_next  = 2'd0;
                    w_daddr_next = addr;
                    if (we) begin
                        w_state_next    = S_STORE;
                        w_memwrite_next = 1'b1;
                        w_wbyte_next    = wdata[31:24];
                    end else begin
                        w_state_next    = S_LOAD;
                        w_memread_next  = 1'b1;
                    end
                end
            end

            S_STORE: begin
                if (r_cnt == 2'd3) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next      = w_cnt_inc;
                    w_memwrite_next = 1'b1;
                    w_daddr_next    = w_addr_inc;
                    w_wbyte_next    = sel_byte(r_wdata, w_cnt_inc);
                end
            end

            S_LOAD: begin
                // Issue side: four reads, then one idle cycle for the
                // last returned byte.
                if (r_memread && (r_cnt != 2'd3)) begin
                    w_cnt_next     = w_cnt_inc;
                    w_memread_next = 1'b1;
                    w_daddr_next   = w_addr_inc;
                end
                // Capture side: lags the issue side by one cycle.
                if (r_pend) begin
                    case (r_ccnt)
                        2'd0:    w_shift_next[31:24] = mem_rbyte;
                        2'd1:    w_shift_next[23:16] = mem_rbyte;
                        2'd2:    w_shift_next[15:8]  = mem_rbyte;
                        default: w_shift_next[7:0]   = mem_rbyte;
                    endcase
                    w_ccnt_next = r_ccnt + 2'd1;
                    if (r_ccnt == 2'd3) begin
                        w_rdata_next = w_shift_next;
                        w_state_next = S_DONE;
                    end
                end
            end

            default: begin  // S_DONE
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign ready     = (r_state == S_IDLE);
    assign done      = (r_state == S_DONE);
    assign rdata     = r_rdata;
    assign daddr     = r_daddr;
    assign mem_wbyte = r_wbyte;
    assign MemRead   = r_memread;
    assign MemWrite  = r_memwrite;

endmodule

// File: tb/tb_dmem_master.sv
`timescale 1ns/1ps
module tb_dmem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done;
    logic [31:0] rdata;
    logic [7:0]  daddr, mem_wbyte;
    logic [7:0]  mem_rbyte = '0;
    logic        MemRead, MemWrite;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn = 0;

    logic [7:0]  tb_mem  [0:255];   // memory the DUT actually talks to
    logic [7:0]  ref_mem [0:255];   // reference contents
    logic [31:0] ref_rdata = '0;

    always #5 clk = ~clk;

    dmem_master #(.AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
        .daddr(daddr), .mem_wbyte(mem_wbyte), .mem_rbyte(mem_rbyte),
        .MemRead(MemRead), .MemWrite(MemWrite)
    );

    // Byte memory with one-cycle read latency.
    always @(posedge clk) begin
        if (MemWrite) tb_mem[daddr] <= mem_wbyte;
        if (MemRead)  mem_rbyte <= tb_mem[daddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One word access starting at a negedge with the block idle.
    // mode 0: drop req after accept; 1: re-request 0x40 store while busy;
    // 2: keep the same req high (back-to-back repeat).
    task automatic access(input logic w, input logic [7:0] a,
                          input logic [31:0] d, input int mode);
        int n;
        logic [7:0]  ea;
        logic [31:0] exp_word;
        n = w ? 5 : 6;
        exp_word = 32'h0;
        if (!w) for (int i = 0; i < 4; i++) begin
            ea = a + 8'(i);
            exp_word = {exp_word[23:0], ref_mem[ea]};
        end
        n_txn++;
        $display("txn %0d %s addr=%h data=%h", n_txn, w ? "store" : "load ", a,
                 w ? d : exp_word);
        chk("ready_pre", 32'(ready), 32'd1);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= n; k++) begin
            if (mode == 0) req = 1'b0;
            if (mode == 1) begin
                req = (k < n - 1); we = 1'b1; addr = 8'h40; wdata = 32'hBAD0BAD0;
            end
            ea = a + 8'(k - 1);
            chk("memwrite", 32'(MemWrite), 32'(w && k <= 4));
            chk("memread",  32'(MemRead),  32'(!w && k <= 4));
            if (k <= 4) chk("daddr", 32'(daddr), 32'(ea));
            if (w && k <= 4) chk("wbyte", 32'(mem_wbyte), 32'((d >> (8 * (4 - k))) & 32'hFF));
            chk("done",  32'(done),  32'(k == n));
            chk("ready", 32'(ready), 32'd0);
            if (w) chk("rdata_hold", rdata, ref_rdata);
            if (!w && k == n) chk("rdata", rdata, exp_word);
            if (k < n) @(negedge clk);
        end
        if (w) for (int i = 0; i < 4; i++) begin
            ea = a + 8'(i);
            ref_mem[ea] = 8'((d >> (8 * (3 - i))) & 32'hFF);
        end
        else ref_rdata = exp_word;
        @(negedge clk);
        chk("ready_post", 32'(ready), 32'd1);
        chk("done_post",  32'(done),  32'd0);
        chk("strobe_post", 32'({MemRead, MemWrite}), 32'd0);
        if (!w) chk("rdata_held", rdata, exp_word);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        // Reset state
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_daddr", 32'(daddr), 32'd0);
        chk("rst_wbyte", 32'(mem_wbyte), 32'd0);
        chk("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: store/load, wrap, busy, back-to-back
        access(1'b1, 8'h10, 32'hDEADBEEF, 0);
        access(1'b0, 8'h10, 32'h0, 0);
        access(1'b1, 8'hFE, 32'h01020304, 0);
        access(1'b0, 8'hFE, 32'h0, 0);
        access(1'b1, 8'h20, 32'h11223344, 1);
        chk("busy_mem40", 32'(tb_mem[8'h40]), 32'(ref_mem[8'h40]));
        access(1'b1, 8'h30, 32'hA5A55A5A, 2);
        access(1'b1, 8'h30, 32'hA5A55A5A, 0);
        access(1'b0, 8'h30, 32'h0, 2);
        access(1'b0, 8'h30, 32'h0, 0);

        // Reset in the middle of a store, after two bytes were written
        n_txn++;
        $display("txn %0d store addr=80 data=cafef00d (reset after 2 bytes)", n_txn);
        req = 1'b1; we = 1'b1; addr = 8'h80; wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        ref_mem[8'h80] = 8'hCA;
        ref_mem[8'h81] = 8'hFE;
        ref_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({done, MemRead, MemWrite, ready}), 32'b0001);
        end

        // Randomized accesses against the reference memory
        for (int t = 0; t < 40; t++) begin
            access(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 1)) * 2);
        end
        req = 1'b0;
        @(negedge clk);

        // Whole-memory comparison catches stray or missing writes
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("mem[%02h]", i), 32'(tb_mem[i]), 32'(ref_mem[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
